// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, per-frame debounce FSM,
// and an 8-nibble hex entry shift register for the seven-segment driver.
module keypad_scanner #(
  parameter int SCAN_BITS = 14,
  parameter int DEB_CNT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] data_out
);

  localparam int         CW  = SCAN_BITS + 2;
  localparam logic [3:0] DEB = 4'(DEB_CNT);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    sync1, row_sync;
  logic [15:0]   frame, img;
  logic          dwell_end, frame_end;
  logic          cls_none, cls_one, accept;
  logic [3:0]    code, cand, cnt, cnt_inc, idx;
  state_t        state;

  assign col_idx   = scan_cnt[CW-1 -: 2];
  assign dwell_end = &scan_cnt[SCAN_BITS-1:0];
  assign frame_end = &scan_cnt;
  assign cnt_inc   = cnt + 4'd1;

  always_comb col_n = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      sync1    <= 4'b1111;
      row_sync <= 4'b1111;
      frame    <= '0;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
      sync1    <= row_n;
      row_sync <= sync1;
      frame    <= img;
    end
  end

  // The image used at frame end already merges the final column's capture,
  // so classification sees all four columns on the same edge.
  always_comb begin
    img = frame;
    idx = '0;
    if (dwell_end)
      for (int r = 0; r < 4; r++) begin
        idx      = {2'(r), col_idx};
        img[idx] = ~row_sync[r];
      end
  end

  always_comb begin
    code = '0;
    for (int i = 0; i < 16; i++)
      if (img[i]) code = 4'(i);
    cls_none = (img == 16'h0000);
    cls_one  = $onehot(img);
  end

  always_comb begin
    accept = 1'b0;
    if (frame_end && cls_one) begin
      if (state == IDLE && DEB == 4'd1) accept = 1'b1;
      if (state == DEB_PRESS && code == cand && cnt_inc == DEB) accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_held <= 1'b0;
    end else if (frame_end) begin
      case (state)
        IDLE: if (cls_one) begin
          cand <= code;
          cnt  <= 4'd1;
          if (DEB == 4'd1) begin
            state    <= HELD;
            key_held <= 1'b1;
          end else state <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!cls_one) state <= IDLE;
          else if (code == cand) begin
            cnt <= cnt_inc;
            if (cnt_inc == DEB) begin
              state    <= HELD;
              key_held <= 1'b1;
            end
          end else begin
            cand <= code;
            cnt  <= 4'd1;
          end
        end
        HELD: if (cls_none) begin
          cnt <= 4'd1;
          if (DEB == 4'd1) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else state <= DEB_RELEASE;
        end
        DEB_RELEASE: begin
          if (!cls_none) state <= HELD;
          else begin
            cnt <= cnt_inc;
            if (cnt_inc == DEB) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear beats a coincident acceptance for data_out only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= code;
      if (clear)       data_out <= '0;
      else if (accept) data_out <= {data_out[27:0], code};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner (SCAN_BITS=2, DEB_CNT=3): a physical
// keypad model drives row_n, and a debounce reference model predicts outputs.
module tb_keypad_scanner;

  localparam int SB  = 2;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic        clear = 1'b0;
  logic [3:0]  col_n, key_code;
  logic        key_valid, key_held;
  logic [31:0] data_out;

  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // reference model state
  bit          m_held;
  int          m_len, m_none;
  logic [3:0]  m_code;
  logic        exp_kv, exp_held;
  logic [3:0]  exp_code;
  logic [31:0] exp_data;

  keypad_scanner #(.SCAN_BITS(SB), .DEB_CNT(DEB)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .clear(clear), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // A pressed key at (row,col) pulls its row low while its column is driven.
  always_comb
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_reset();
    m_held = 0; m_len = 0; m_none = 0; m_code = 0;
    exp_kv = 0; exp_held = 0; exp_code = 0; exp_data = 0;
  endtask

  task automatic model_step(input logic [15:0] mask, input bit clr);
    int n;
    logic [3:0] c;
    n = $countones(mask);
    c = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) c = 4'(i);
    exp_kv = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_len > 0 && c == m_code) m_len++;
        else begin m_code = c; m_len = 1; end
        if (m_len == DEB) begin
          m_held = 1; m_len = 0; m_none = 0;
          exp_kv = 1; exp_code = c;
          exp_data = {exp_data[27:0], c};
        end
      end else m_len = 0;
    end else begin
      if (n == 0) begin
        m_none++;
        if (m_none == DEB) begin m_held = 0; m_none = 0; end
      end else m_none = 0;
    end
    if (clr) exp_data = 0;
    exp_held = m_held;
  endtask

  // Starts with scan_cnt at 0; ends #1 after the frame-end edge.
  task automatic run_frame(input logic [15:0] mask, input bit clr);
    logic [3:0] exp_col;
    bit bad_col, stray;
    keys = mask; bad_col = 0; stray = 0;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      if (col_n !== exp_col) bad_col = 1;
      if (i > 0 && key_valid !== 1'b0) stray = 1;
      if (i == 15) clear = clr;
      @(posedge clk); #1;
    end
    clear = 0;
    model_step(mask, clr);
    if (key_valid === 1'b1) pulses++;
    checks++; if (bad_col) begin errors++; $display("FAIL col_seq col_n did not follow 1110/1101/1011/0111"); end
    checks++; if (stray) begin errors++; $display("FAIL stray_pulse key_valid high off frame end"); end
    checks++; if (key_valid !== exp_kv) begin errors++; $display("FAIL key_valid got %b exp %b", key_valid, exp_kv); end
    checks++; if (key_code !== exp_code) begin errors++; $display("FAIL key_code got %h exp %h", key_code, exp_code); end
    checks++; if (key_held !== exp_held) begin errors++; $display("FAIL key_held got %b exp %b", key_held, exp_held); end
    checks++; if (data_out !== exp_data) begin errors++; $display("FAIL data_out got %h exp %h", data_out, exp_data); end
  endtask

  task automatic do_reset(input logic [15:0] mask);
    keys = mask; clear = 0; reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    pulses = 0;
    reset = 1;
  endtask

  task automatic test_reset();
    keys = 16'h0040; reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rst_col got %b exp 1110", col_n); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_kv got %b exp 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held got %b exp 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code got %h exp 0", key_code); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
  endtask

  task automatic test_single();
    do_reset(16'h0);
    repeat (4) run_frame(16'h0040, 0);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", pulses); end
    checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_code got %h exp 6", key_code); end
    checks++; if (data_out !== 32'h6) begin errors++; $display("FAIL single_data got %h exp 00000006", data_out); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held got %b exp 1", key_held); end
  endtask

  task automatic test_bounce();
    do_reset(16'h0);
    repeat (4) begin
      repeat (2) run_frame(16'h0040, 0);
      run_frame(16'h0, 0);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses got %0d exp 0", pulses); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held got %b exp 0", key_held); end
  endtask

  task automatic test_entry();
    do_reset(16'h0);
    for (int k = 1; k <= 9; k++) begin
      repeat (3) run_frame(16'h1 << k, 0);
      repeat (3) run_frame(16'h0, 0);
      if (k == 3) begin
        checks++; if (data_out !== 32'h00000123) begin errors++; $display("FAIL entry3 got %h exp 00000123", data_out); end
      end
    end
    checks++; if (data_out !== 32'h23456789) begin errors++; $display("FAIL entry9 got %h exp 23456789", data_out); end
    checks++; if (pulses !== 9) begin errors++; $display("FAIL entry_pulses got %0d exp 9", pulses); end
  endtask

  task automatic test_multi();
    do_reset(16'h0);
    repeat (4) run_frame(16'h0003, 0);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL multi_idle_pulses got %0d exp 0", pulses); end
    repeat (3) run_frame(16'h0020, 0);
    repeat (3) run_frame(16'h00A0, 0);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL multi_add_pulses got %0d exp 1", pulses); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL multi_held got %b exp 1", key_held); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL multi_code got %h exp 5", key_code); end
  endtask

  task automatic test_release();
    do_reset(16'h0);
    repeat (3) run_frame(16'h1000, 0);
    repeat (2) run_frame(16'h0, 0);
    run_frame(16'h1000, 0);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rel2_pulses got %0d exp 1", pulses); end
    repeat (3) run_frame(16'h0, 0);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rel3_held got %b exp 0", key_held); end
    repeat (3) run_frame(16'h1000, 0);
    checks++; if (pulses !== 2) begin errors++; $display("FAIL repress_pulses got %0d exp 2", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0);
    repeat (3) run_frame(16'h0400, 0);
    repeat (3) run_frame(16'h0, 0);
    repeat (2) run_frame(16'h0200, 0);
    repeat (6) @(posedge clk);
    #2 reset = 0;
    #1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL mid_col got %b exp 1110", col_n); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_code got %h exp 0", key_code); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", data_out); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_held got %b exp 0", key_held); end
    do_reset(16'h0200);
    repeat (4) run_frame(16'h0200, 0);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_repress_pulses got %0d exp 1", pulses); end
    repeat (3) run_frame(16'h0, 0);
    repeat (2) run_frame(16'h0010, 0);
    run_frame(16'h0010, 1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL clr_kv got %b exp 1", key_valid); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL clr_data got %h exp 0", data_out); end
    checks++; if (key_code !== 4'h4) begin errors++; $display("FAIL clr_code got %h exp 4", key_code); end
  endtask

  task automatic test_random();
    logic [15:0] m;
    int kind;
    do_reset(16'h0);
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) m = 16'h0;
      else if (kind < 8) m = 16'h1 << $urandom_range(0, 15);
      else begin
        m = 16'h1 << $urandom_range(0, 15);
        m = m | (16'h1 << $urandom_range(0, 15));
      end
      repeat ($urandom_range(1, 4)) run_frame(m, ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_entry();
    test_multi();
    test_release();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_BITS, default 14: each column is driven for 2^SCAN_BITS clk cycles; legal minimum 2.
REQ-002 Parameter DEB_CNT, default 3: number of consecutive identical scan frames needed to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single clock; every flop is on the rising edge.
REQ-004 reset  input  1  asynchronous assert, active-low; low forces reset state immediately.
REQ-005 row_n  input  4  keypad row sense, active-low, pulled up, asynchronous to clk.
REQ-006 clear  input  1  synchronous clear of data_out, active-high.
REQ-007 col_n  output  4  keypad column drive, active-low, one-hot.
REQ-008 key_code  output  4  code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-010 key_held  output  1  high while an accepted key is considered pressed.
REQ-011 data_out  output  32  hex entry register, formatted for the seven-segment driver data input.

Function
REQ-012 scan_cnt is a free-running (SCAN_BITS+2)-bit counter that wraps to 0; col_idx = scan_cnt[SCAN_BITS+1:SCAN_BITS].
REQ-013 col_n = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for col_idx 0, 1, 2, 3; exactly one bit is low at all times.
REQ-014 row_n passes through a 2-flop synchronizer before any use.
REQ-015 Synchronized rows are captured on the last cycle of each column dwell (low SCAN_BITS bits of scan_cnt all ones) into a 16-bit frame image at bit row*4+col.
REQ-016 The frame ends at scan_cnt all ones and is classified from the captured image:
- NONE: no bits set.
- ONE: exactly one bit set; the candidate code is {row_idx[1:0], col_idx[1:0]}.
- MULTI: two or more bits set.
REQ-017 The FSM advances only on frame-end edges, with states IDLE, DEB_PRESS, HELD and DEB_RELEASE, using a 4-bit counter cnt.
REQ-018 IDLE:
- ONE -> DEB_PRESS, with cand = code and cnt = 1; if DEB_CNT = 1, go directly to acceptance (REQ-019).
- NONE or MULTI -> stay in IDLE.
REQ-019 DEB_PRESS:
- ONE with the same code -> cnt+1; when cnt+1 equals DEB_CNT, accept: go to HELD, key_code = cand, key_valid = 1.
- ONE with a different code -> restart with cand = new code, cnt = 1.
- NONE or MULTI -> IDLE.
REQ-020 HELD:
- NONE -> DEB_RELEASE, cnt = 1; if DEB_CNT = 1, go directly to IDLE.
- ONE or MULTI -> stay in HELD; this includes a different key or an added key, and no new acceptance occurs.
REQ-021 DEB_RELEASE:
- NONE -> cnt+1; when cnt+1 equals DEB_CNT, go to IDLE.
- ONE or MULTI -> HELD, with no new key_valid.
REQ-022 key_valid is registered: high exactly one clk cycle, beginning at the accepting frame-end edge, and low otherwise.
REQ-023 key_held = 1 in HELD and DEB_RELEASE, 0 in IDLE and DEB_PRESS; it is registered and updates on the same edge as the state.
REQ-024 On the accepting edge, data_out <= {data_out[27:0], cand}; the oldest nibble is discarded, so after 8 or more keys data_out holds the last 8.
REQ-025 clear = 1 sets data_out to 0 on the next edge; if clear coincides with an acceptance, clear wins and the nibble is dropped, while key_valid and key_code still update.
REQ-026 key_code holds its value until the next acceptance.
REQ-027 Press latency is at least DEB_CNT frames and less than DEB_CNT+1 frames (one frame = 4*2^SCAN_BITS cycles) from a stable contact, plus 2 synchronizer cycles.

Reset
REQ-028 While reset is low, the block is held in its reset state: scan_cnt = 0, col_n = 4'b1110, synchronizer = 4'b1111 (inactive), state = IDLE, cnt = 0, cand = 0, key_code = 0, key_valid = 0, key_held = 0, data_out = 0.
REQ-029 Reset asserted mid-debounce or mid-hold discards all progress; after release, scanning restarts at column 0 and any still-held key must be re-debounced in full, producing one new key_valid.

Verification (SCAN_BITS=2, DEB_CNT=3, frame = 16 cycles)
REQ-030 Hold row 1 / col 2 steady -> exactly one key_valid pulse, 3 frame-ends after the first frame that sees the key; key_code = 4'h6, data_out = 32'h00000006, key_held = 1.
REQ-031 Press 2 frames, release 1 frame, repeat -> no key_valid and key_held stays 0; col_n cycles 1110 -> 1101 -> 1011 -> 0111 every 4 cycles.
REQ-032 Enter keys with codes 1 through 9 with clean release between them -> data_out = 32'h00000123 after 3 keys and 32'h23456789 after 9 keys.
REQ-033 Press codes 0 and 1 together from IDLE -> no key_valid; press code 5, accept it, then add code 7 -> key_held stays 1 and no second pulse.
REQ-034 Release for 2 frames, then re-press -> no pulse; release for 3 frames -> key_held = 0; re-press -> new key_valid.
REQ-035 Reset pulled low mid-DEB_PRESS -> all outputs take reset values combinationally, with col_n = 4'b1110; clear asserted on the accepting edge -> data_out = 0 while key_valid = 1.
